// File: rtl/fpga_run_pkg.sv
// fpga_run_pkg
// Shared types and constants for the FPGA run controller:
//   - run_state_e   : controller FSM states
//   - ALU_*         : alu_sel codes
//   - INSN_* / ADDI_* / RTYPE_* : RV32I encodings used by the generated program
//   - ERR_*         : bit positions inside err_in
//   - rtype_insn()  : alu_sel -> R-type instruction x3 = x1 op x2
package fpga_run_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [31:0] INSN_NOP   = 32'h0000_0013;  // addi x0,x0,0
    // Low 20 bits of addi rd,x0,imm; the 12-bit immediate goes on top.
    localparam logic [19:0] ADDI_X1_LO = 20'h00093;
    localparam logic [19:0] ADDI_X2_LO = 20'h00113;

    localparam logic [31:0] RTYPE_ADD = 32'h0020_81B3;
    localparam logic [31:0] RTYPE_SUB = 32'h4020_81B3;
    localparam logic [31:0] RTYPE_AND = 32'h0020_F1B3;
    localparam logic [31:0] RTYPE_OR  = 32'h0020_E1B3;
    localparam logic [31:0] RTYPE_XOR = 32'h0020_C1B3;
    localparam logic [31:0] RTYPE_SLL = 32'h0020_91B3;
    localparam logic [31:0] RTYPE_SRL = 32'h0020_D1B3;
    localparam logic [31:0] RTYPE_SLT = 32'h0020_A1B3;

    // err_in bit positions, MSB first {d_err_dmem, s_err_dmem, d_err_imem, s_err_imem}
    localparam int ERR_S_IMEM = 0;
    localparam int ERR_D_IMEM = 1;
    localparam int ERR_S_DMEM = 2;
    localparam int ERR_D_DMEM = 3;

    function automatic logic [31:0] rtype_insn(input logic [2:0] sel);
        logic [31:0] insn;
        case (sel)
            ALU_ADD: insn = RTYPE_ADD;
            ALU_SUB: insn = RTYPE_SUB;
            ALU_AND: insn = RTYPE_AND;
            ALU_OR:  insn = RTYPE_OR;
            ALU_XOR: insn = RTYPE_XOR;
            ALU_SLL: insn = RTYPE_SLL;
            ALU_SRL: insn = RTYPE_SRL;
            default: insn = RTYPE_SLT;
        endcase
        return insn;
    endfunction

endpackage

// File: rtl/fpga_run_ctrl_if.sv
// fpga_run_ctrl_if
// Connection between the run controller and the pipelined CPU.
//   imem_we / imem_waddr / imem_wdata : IMEM write port (controller -> CPU)
//   cpu_rst                           : CPU reset (controller -> CPU)
//   loader_done                       : CPU loader-done qualifier (controller -> CPU)
//   cpu_result                        : CPU write-back ResultW (CPU -> controller)
//
// Handshake: the IMEM write port is a pure strobe with no ready. A word is
// written on every clock edge where imem_we is 1; the memory must accept it.
// cpu_result is sampled by the controller without any valid qualifier, at a
// fixed cycle of the run window.
interface fpga_run_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_rst;
    logic              loader_done;
    logic [DATA_W-1:0] cpu_result;

    modport master (
        output imem_we, imem_waddr, imem_wdata, cpu_rst, loader_done,
        input  cpu_result
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, cpu_rst, loader_done,
        output cpu_result
    );
endinterface

// File: rtl/fpga_run_ctrl_rv_prog_rom.sv
// rv_prog_rom
// Combinational generator of the test program word at a given index.
//   idx      in  : word index within the program
//   op1, op2 in  : operands, placed in addi immediates (zero-extended)
//   alu_sel  in  : selects the R-type operation for word 2
//   insn     out : 32-bit RV32I instruction
// Program: addi x1,x0,op1 ; addi x2,x0,op2 ; x3 = x1 op x2 ; NOP...
module rv_prog_rom
    import fpga_run_pkg::*;
#(
    parameter int OP_W  = 8,
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [OP_W-1:0]  op1,
    input  logic [OP_W-1:0]  op2,
    input  logic [2:0]       alu_sel,
    output logic [31:0]      insn
);

    always_comb begin
        insn = INSN_NOP;
        if (idx == IDX_W'(0)) begin
            insn = {12'(op1), ADDI_X1_LO};
        end else if (idx == IDX_W'(1)) begin
            insn = {12'(op2), ADDI_X2_LO};
        end else if (idx == IDX_W'(2)) begin
            insn = rtype_insn(alu_sel);
        end
    end

endmodule

// File: rtl/fpga_run_ctrl.sv
// fpga_run_ctrl
// Loads a generated RV32I program into the CPU's IMEM while holding the CPU
// in reset, releases it for a fixed run window, captures the write-back
// result at a set cycle and keeps sticky, saturating ECC error counters.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle load-and-run request (ignored while busy)
//   auto_rerun      : reload from DONE when the live configuration changes
//   op1, op2, alu_sel : program configuration, latched when a load starts
//   err_in, err_clr : error inputs (sampled only in RUN), clear of flags/counters
//   bus             : IMEM write port, cpu_rst, loader_done, cpu_result
//   busy            : high in LOAD or RUN
//   result, result_valid : captured CPU result
//   err_sticky, err_count : sticky flags and counters (counter i in slice i)
//   dbg_state       : current FSM state
module fpga_run_ctrl
    import fpga_run_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int OP_W        = 8,
    parameter int PROG_WORDS  = 8,
    parameter int CAPTURE_CYC = 7,
    parameter int RUN_CYCLES  = 32,
    parameter int NUM_ERR     = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           auto_rerun,
    input  logic [OP_W-1:0]                op1,
    input  logic [OP_W-1:0]                op2,
    input  logic [2:0]                     alu_sel,
    input  logic [NUM_ERR-1:0]             err_in,
    input  logic                           err_clr,
    fpga_run_ctrl_if.master                bus,
    output logic                           busy,
    output logic [DATA_W-1:0]              result,
    output logic                           result_valid,
    output logic [NUM_ERR-1:0]             err_sticky,
    output logic [NUM_ERR*ERR_CNT_W-1:0]   err_count,
    output run_state_e                     dbg_state
);

    localparam int IDX_W = $clog2(PROG_WORDS + 1);
    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    run_state_e        state, next_state;
    logic              launch;
    logic              cfg_changed;
    logic [OP_W-1:0]   cfg_op1, cfg_op2;
    logic [2:0]        cfg_sel;
    // load_idx is the index of the NEXT word to put on the write port.
    logic [IDX_W-1:0]  load_idx;
    logic [CNT_W-1:0]  run_cnt;
    logic [IDX_W-1:0]  rom_idx;
    logic [OP_W-1:0]   rom_op1, rom_op2;
    logic [2:0]        rom_sel;
    logic [31:0]       rom_insn;
    logic              run_active;

    assign dbg_state  = state;
    assign run_active = (state == ST_RUN);
    assign cfg_changed = (op1 != cfg_op1) || (op2 != cfg_op2) || (alu_sel != cfg_sel);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD;
                    launch     = 1'b1;
                end
            end
            ST_LOAD: begin
                // load_idx == PROG_WORDS means the last word is on the port now.
                if (load_idx == IDX_W'(PROG_WORDS)) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_cnt == CNT_W'(RUN_CYCLES - 1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start || (auto_rerun && cfg_changed)) begin
                    next_state = ST_LOAD;
                    launch     = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Word 0 leaves on the same edge that latches the configuration, so the
    // ROM sees the live inputs during a launch and the latched copy afterwards.
    assign rom_idx = launch ? '0 : load_idx;
    assign rom_op1 = launch ? op1 : cfg_op1;
    assign rom_op2 = launch ? op2 : cfg_op2;
    assign rom_sel = launch ? alu_sel : cfg_sel;

    rv_prog_rom #(
        .OP_W  (OP_W),
        .IDX_W (IDX_W)
    ) u_rom (
        .idx     (rom_idx),
        .op1     (rom_op1),
        .op2     (rom_op2),
        .alu_sel (rom_sel),
        .insn    (rom_insn)
    );

    // ---------------- Load / run datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_op1         <= '0;
            cfg_op2         <= '0;
            cfg_sel         <= '0;
            load_idx        <= '0;
            run_cnt         <= '0;
            bus.imem_we     <= 1'b0;
            bus.imem_waddr  <= '0;
            bus.imem_wdata  <= '0;
            bus.cpu_rst     <= 1'b1;
            bus.loader_done <= 1'b0;
            busy            <= 1'b0;
            result          <= '0;
            result_valid    <= 1'b0;
        end else begin
            // Control outputs are registered copies of the next state.
            busy            <= (next_state == ST_LOAD) || (next_state == ST_RUN);
            bus.cpu_rst     <= (next_state != ST_RUN);
            bus.loader_done <= (next_state == ST_RUN);
            bus.imem_we     <= 1'b0;

            if (launch) begin
                cfg_op1        <= op1;
                cfg_op2        <= op2;
                cfg_sel        <= alu_sel;
                load_idx       <= IDX_W'(1);
                result_valid   <= 1'b0;
                bus.imem_we    <= 1'b1;
                bus.imem_waddr <= '0;
                bus.imem_wdata <= DATA_W'(rom_insn);
            end else if ((state == ST_LOAD) && (load_idx != IDX_W'(PROG_WORDS))) begin
                load_idx       <= load_idx + IDX_W'(1);
                bus.imem_we    <= 1'b1;
                bus.imem_waddr <= ADDR_W'({load_idx, 2'b00});
                bus.imem_wdata <= DATA_W'(rom_insn);
            end

            if (run_active) begin
                run_cnt <= run_cnt + CNT_W'(1);
                if (run_cnt == CNT_W'(CAPTURE_CYC)) begin
                    result       <= bus.cpu_result;
                    result_valid <= 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    // ---------------- Error flag / counter bank ----------------
    for (genvar i = 0; i < NUM_ERR; i++) begin : g_err
        logic                 sticky;
        logic [ERR_CNT_W-1:0] cnt;
        logic                 hit;

        assign hit = run_active && err_in[i];

        // A hit in the clear cycle wins: the flag stays set and the count
        // restarts at one.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sticky <= 1'b0;
                cnt    <= '0;
            end else if (hit) begin
                sticky <= 1'b1;
                if (err_clr) begin
                    cnt <= ERR_CNT_W'(1);
                end else if (cnt != '1) begin
                    cnt <= cnt + ERR_CNT_W'(1);
                end
            end else if (err_clr) begin
                sticky <= 1'b0;
                cnt    <= '0;
            end
        end

        assign err_sticky[i]                        = sticky;
        assign err_count[i*ERR_CNT_W +: ERR_CNT_W]  = cnt;
    end

endmodule

// File: tb/tb_fpga_run_ctrl.sv
module tb_fpga_run_ctrl;
    import fpga_run_pkg::*;

    localparam int P    = 8;
    localparam int CAP  = 7;
    localparam int RUNC = 32;
    localparam int NE   = 4;
    localparam int CW   = 2;

    localparam logic [31:0] RT_TAB [8] = '{
        32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
        32'h0020C1B3, 32'h002091B3, 32'h0020D1B3, 32'h0020A1B3
    };

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0, auto_rerun = 1'b0, err_clr = 1'b0;
    logic [7:0]    op1 = '0, op2 = '0;
    logic [2:0]    alu_sel = '0;
    logic [NE-1:0] err_in = '0;
    logic          busy, result_valid;
    logic [31:0]   result;
    logic [NE-1:0] err_sticky;
    logic [NE*CW-1:0] err_count;
    run_state_e    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    fpga_run_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    fpga_run_ctrl #(
        .DATA_W(32), .ADDR_W(32), .OP_W(8), .PROG_WORDS(P), .CAPTURE_CYC(CAP),
        .RUN_CYCLES(RUNC), .NUM_ERR(NE), .ERR_CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .auto_rerun(auto_rerun),
        .op1(op1), .op2(op2), .alu_sel(alu_sel), .err_in(err_in), .err_clr(err_clr),
        .bus(bus), .busy(busy), .result(result), .result_valid(result_valid),
        .err_sticky(err_sticky), .err_count(err_count), .dbg_state(dbg_state)
    );

    // ---------------- model CPU ----------------
    // Counts cycles out of reset; shows the expected ALU value only in the
    // capture cycle and a cycle-tagged junk value otherwise.
    int unsigned cpu_cyc = 0;
    logic [31:0] cpu_value = '0;
    always @(posedge clk) begin
        if (bus.cpu_rst) cpu_cyc <= 0;
        else             cpu_cyc <= cpu_cyc + 1;
    end
    assign bus.cpu_result = (!bus.cpu_rst && cpu_cyc == CAP) ? cpu_value
                                                              : (32'hDEAD_0000 | cpu_cyc);

    // ---------------- IMEM write monitor / scoreboard ----------------
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    always @(posedge clk) begin
        if (bus.imem_we === 1'b1) obs_q.push_back({bus.imem_waddr, bus.imem_wdata});
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_insn(input int idx, input logic [7:0] a, b,
                                             input logic [2:0] sel);
        if (idx == 0) return 32'(a) * 32'h0010_0000 + 32'h0000_0093;
        if (idx == 1) return 32'(b) * 32'h0010_0000 + 32'h0000_0113;
        if (idx == 2) return RT_TAB[sel];
        return 32'h0000_0013;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [7:0] a, b, input logic [2:0] sel);
        int x;
        int y;
        x = int'(a);
        y = int'(b);
        case (sel)
            3'd0: return 32'(x + y);
            3'd1: return 32'(x - y);
            3'd2: return 32'(x & y);
            3'd3: return 32'(x | y);
            3'd4: return 32'(x ^ y);
            3'd5: return 32'(x << (y % 32));
            3'd6: return 32'(x >> (y % 32));
            default: return (x < y) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] a, b, input logic [2:0] s);
        @(negedge clk);
        op1 = a; op2 = b; alu_sel = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input run_state_e st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (dbg_state == st) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        n_cmp++;
        if ({bus.imem_we, bus.cpu_rst, bus.loader_done, busy, result_valid} !== 5'b01000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 01000",
                     {bus.imem_we, bus.cpu_rst, bus.loader_done, busy, result_valid});
        end
        n_cmp++;
        if ({bus.imem_waddr, bus.imem_wdata, result} !== 96'd0) begin
            n_err++;
            $display("FAIL reset_data: waddr=%h wdata=%h result=%h want 0",
                     bus.imem_waddr, bus.imem_wdata, result);
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE || err_sticky !== '0 || err_count !== '0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d sticky=%b count=%h want IDLE/0/0",
                     dbg_state, err_sticky, err_count);
        end
        // errors outside RUN are ignored
        err_in = 4'hF;
        repeat (4) @(negedge clk);
        err_in = '0;
        n_cmp++;
        if (err_sticky !== '0 || err_count !== '0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL idle_err_ignored: sticky=%b count=%h writes=%0d want 0/0/0",
                     err_sticky, err_count, obs_q.size());
        end
    endtask

    task automatic test_basic();
        bit ok;
        obs_q.delete();
        cpu_value = ref_alu(8'd10, 8'd5, 3'd0);
        pulse_start(8'd10, 8'd5, 3'd0);
        for (int k = 0; k < P; k++) begin
            n_cmp++;
            if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 32'(4 * k) ||
                bus.imem_wdata !== ref_insn(k, 8'd10, 8'd5, 3'd0) ||
                bus.cpu_rst !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL load_word%0d: we=%b addr=%h data=%h cpu_rst=%b busy=%b want 1/%h/%h/1/1",
                         k, bus.imem_we, bus.imem_waddr, bus.imem_wdata, bus.cpu_rst, busy,
                         32'(4 * k), ref_insn(k, 8'd10, 8'd5, 3'd0));
            end
            @(negedge clk);
        end
        // RUN count 0
        n_cmp++;
        if ({bus.imem_we, bus.cpu_rst, bus.loader_done, busy, result_valid} !== 5'b00110) begin
            n_err++;
            $display("FAIL run_entry: got %b want 00110",
                     {bus.imem_we, bus.cpu_rst, bus.loader_done, busy, result_valid});
        end
        for (int c = 1; c <= CAP; c++) begin
            @(negedge clk);
            n_cmp++;
            if (result_valid !== 1'b0) begin
                n_err++;
                $display("FAIL early_valid: count %0d valid=%b want 0", c, result_valid);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b1 || result !== 32'd15) begin
            n_err++;
            $display("FAIL capture: valid=%b result=%h want 1/0000000f", result_valid, result);
        end
        wait_state(ST_DONE, 100, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL done_timeout: state=%0d want DONE", dbg_state);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.cpu_rst, bus.loader_done, busy, result_valid} !== 4'b1001 || result !== 32'd15) begin
            n_err++;
            $display("FAIL done_hold: ctrl=%b result=%h want 1001/0000000f",
                     {bus.cpu_rst, bus.loader_done, busy, result_valid}, result);
        end
    endtask

    task automatic test_alu_ops();
        bit ok;
        logic [7:0]  a, b;
        logic [2:0]  s;
        logic [63:0] e, o;
        for (int t = 0; t < 13; t++) begin
            if (t < 7) begin
                a = 8'd10; b = 8'd5; s = 3'(t + 1);
            end else begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                s = 3'($urandom_range(0, 7));
            end
            obs_q.delete();
            cpu_value = ref_alu(a, b, s);
            pulse_start(a, b, s);
            wait_state(ST_DONE, 100, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL alu_done_timeout: case %0d state=%0d", t, dbg_state);
            end
            for (int k = 0; k < P; k++) exp_q.push_back({32'(4 * k), ref_insn(k, a, b, s)});
            n_cmp++;
            if (obs_q.size() != P) begin
                n_err++;
                $display("FAIL alu_wr_count: case %0d got %0d want %0d", t, obs_q.size(), P);
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
                n_cmp++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL alu_write: case %0d got %h want %h", t, o, e);
                end
            end
            n_cmp++;
            if (result_valid !== 1'b1 || result !== cpu_value) begin
                n_err++;
                $display("FAIL alu_result: case %0d a=%0d b=%0d sel=%0d valid=%b got %h want %h",
                         t, a, b, s, result_valid, result, cpu_value);
            end
        end
    endtask

    task automatic test_errors();
        bit ok;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        err_in = 4'hF;
        repeat (3) @(negedge clk);
        err_in = '0;
        n_cmp++;
        if (err_sticky !== '0 || err_count !== '0) begin
            n_err++;
            $display("FAIL done_err_ignored: sticky=%b count=%h want 0/0", err_sticky, err_count);
        end
        cpu_value = ref_alu(8'd10, 8'd5, 3'd0);
        pulse_start(8'd10, 8'd5, 3'd0);
        wait_state(ST_RUN, 20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL err_run_timeout: state=%0d want RUN", dbg_state);
        end
        err_in = 4'b0001;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (err_count[1:0] !== 2'd3 || err_sticky !== 4'b0001) begin
            n_err++;
            $display("FAIL err_count3: count0=%0d sticky=%b want 3/0001", err_count[1:0], err_sticky);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (err_count[1:0] !== 2'd1 || err_sticky[0] !== 1'b1) begin
            n_err++;
            $display("FAIL clr_vs_set: count0=%0d sticky0=%b want 1/1", err_count[1:0], err_sticky[0]);
        end
        err_in = 4'b1000;
        repeat (6) @(negedge clk);
        err_in = '0;
        n_cmp++;
        if (err_count !== 8'b11_00_00_01 || err_sticky !== 4'b1001) begin
            n_err++;
            $display("FAIL saturate: count=%b sticky=%b want 11000001/1001", err_count, err_sticky);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (err_count !== '0 || err_sticky !== '0) begin
            n_err++;
            $display("FAIL err_clear: count=%h sticky=%b want 0/0", err_count, err_sticky);
        end
        wait_state(ST_DONE, 100, ok);
        n_cmp++;
        if (!ok || result !== 32'd15 || result_valid !== 1'b1) begin
            n_err++;
            $display("FAIL err_run_result: ok=%b result=%h valid=%b want 1/0000000f/1",
                     ok, result, result_valid);
        end
    endtask

    task automatic test_auto_rerun();
        bit ok;
        obs_q.delete();
        // without auto_rerun a config change in DONE does nothing
        @(negedge clk); op2 = 8'd6;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dbg_state !== ST_DONE || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL no_auto: state=%0d writes=%0d want DONE/0", dbg_state, obs_q.size());
        end
        cpu_value = ref_alu(8'd10, 8'd6, 3'd0);
        auto_rerun = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 32'd0 ||
            bus.imem_wdata !== ref_insn(0, 8'd10, 8'd6, 3'd0) || result_valid !== 1'b0) begin
            n_err++;
            $display("FAIL auto_word0: we=%b addr=%h data=%h valid=%b want 1/0/%h/0",
                     bus.imem_we, bus.imem_waddr, bus.imem_wdata, result_valid,
                     ref_insn(0, 8'd10, 8'd6, 3'd0));
        end
        @(negedge clk);
        n_cmp++;
        if (bus.imem_waddr !== 32'd4 || bus.imem_wdata !== 32'h0060_0113) begin
            n_err++;
            $display("FAIL auto_word1: addr=%h data=%h want 4/00600113",
                     bus.imem_waddr, bus.imem_wdata);
        end
        // start and a config change while busy must not disturb the load
        op1 = 8'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op1 = 8'd10;
        for (int k = 2; k < P; k++) begin
            n_cmp++;
            if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 32'(4 * k) ||
                bus.imem_wdata !== ref_insn(k, 8'd10, 8'd6, 3'd0)) begin
                n_err++;
                $display("FAIL busy_start_word%0d: we=%b addr=%h data=%h want 1/%h/%h", k,
                         bus.imem_we, bus.imem_waddr, bus.imem_wdata, 32'(4 * k),
                         ref_insn(k, 8'd10, 8'd6, 3'd0));
            end
            @(negedge clk);
        end
        wait_state(ST_DONE, 100, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (!ok || dbg_state !== ST_DONE || result !== 32'd16 || obs_q.size() != P) begin
            n_err++;
            $display("FAIL auto_result: ok=%b state=%0d result=%h writes=%0d want 1/DONE/00000010/%0d",
                     ok, dbg_state, result, obs_q.size(), P);
        end
        auto_rerun = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        pulse_start(8'd10, 8'd5, 3'd0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.imem_we !== 1'b1 || bus.imem_waddr !== 32'd12) begin
            n_err++;
            $display("FAIL pre_rst_word3: we=%b addr=%h want 1/0000000c", bus.imem_we, bus.imem_waddr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.imem_we, bus.cpu_rst, bus.loader_done, busy, result_valid} !== 5'b01000 ||
            dbg_state !== ST_IDLE || result !== 32'd0) begin
            n_err++;
            $display("FAIL async_rst: ctrl=%b state=%0d result=%h want 01000/IDLE/0",
                     {bus.imem_we, bus.cpu_rst, bus.loader_done, busy, result_valid},
                     dbg_state, result);
        end
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dbg_state !== ST_IDLE || bus.imem_we !== 1'b0 || busy !== 1'b0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL post_rst_idle: state=%0d we=%b busy=%b writes=%0d want IDLE/0/0/0",
                     dbg_state, bus.imem_we, busy, obs_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_alu_ops();
        test_errors();
        test_auto_rerun();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
